// File: rtl/sd_pkg.sv
// Shared encodings, frame geometry and FSM state type for the SD command engine.
package sd_pkg;

  localparam logic [1:0] RESP_NONE        = 2'd0;
  localparam logic [1:0] RESP_SHORT       = 2'd1;
  localparam logic [1:0] RESP_LONG        = 2'd2;
  localparam logic [1:0] RESP_SHORT_NOCRC = 2'd3;

  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } sd_state_e;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first, zero initial value.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD-bus command/response engine: free-running divided sd_clk, CRC7-protected
// command transmit, short/long response receive with timeout and CRC checks.
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV      = 34,
  parameter int RESP_TIMEOUT = 64,
  parameter int GAP_CYCLES   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         resp_valid,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data,
  output logic         resp_crc_err,
  output logic         resp_timeout,
  output logic         sd_clk,
  output logic         sd_cmd_out,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_in
);

  localparam int               DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_TC       = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0]      CRC_COV_BITS = 16'd40;

  sd_state_e        state, state_d;
  logic [DIV_W-1:0] div_cnt;
  logic             div_tc, rise_stb, fall_stb;
  logic [15:0]      cnt, cnt_inc, frame_len;
  logic [1:0]       type_q;
  logic [39:0]      tx_sr;
  logic [126:0]     rx_sr;
  logic [127:0]     rx_next;
  logic [6:0]       crc_tx, crc_rx;
  logic [2:0]       crc_pos;
  logic             tx_bit, tx_crc_en, rx_crc_en, short_crc_bad;
  logic             accept, send_done, rx_start, tmo_hit, rx_done, gap_done;

  assign div_tc    = (div_cnt == DIV_TC);
  assign rise_stb  = div_tc & ~sd_clk;
  assign fall_stb  = div_tc &  sd_clk;
  assign cnt_inc   = cnt + 16'd1;
  assign frame_len = (type_q == RESP_LONG) ? 16'(LONG_LEN) : 16'(SHORT_LEN);
  assign cmd_ready = (state == ST_IDLE);

  // The start bit is 0 and the CRC starts at 0, so skipping it leaves the CRC unchanged.
  assign rx_next   = {rx_sr, sd_cmd_in};
  assign tx_crc_en = (state == ST_SEND) & fall_stb & (cnt < CRC_COV_BITS);
  assign rx_crc_en = (state == ST_RECV) & rise_stb & (cnt < CRC_COV_BITS);
  assign short_crc_bad = (crc_rx != rx_next[7:1]) | ~rx_next[0];

  // Bits 40..46 of the frame carry crc[6]..crc[0]; cnt[2:0] runs 0..6 over that span.
  assign crc_pos = 3'd6 - cnt[2:0];

  always_comb begin
    tx_bit = 1'b1;
    if (cnt < CRC_COV_BITS) begin
      tx_bit = tx_sr[39];
    end else if (cnt < 16'd47) begin
      tx_bit = crc_tx[crc_pos];
    end
  end

  sd_crc7 u_crc_tx (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (tx_crc_en),
    .din   (tx_sr[39]),
    .crc   (crc_tx)
  );

  sd_crc7 u_crc_rx (
    .clk   (clk),
    .rst   (rst),
    .clear (rx_start),
    .en    (rx_crc_en),
    .din   (sd_cmd_in),
    .crc   (crc_rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    send_done = 1'b0;
    rx_start  = 1'b0;
    tmo_hit   = 1'b0;
    rx_done   = 1'b0;
    gap_done  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (fall_stb && (cnt == 16'(SHORT_LEN))) begin
          send_done = 1'b1;
          state_d   = (type_q == RESP_NONE) ? ST_GAP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rise_stb) begin
          if (!sd_cmd_in) begin
            rx_start = 1'b1;
            state_d  = ST_RECV;
          end else if (cnt_inc == 16'(RESP_TIMEOUT)) begin
            tmo_hit = 1'b1;
            state_d = ST_GAP;
          end
        end
      end
      ST_RECV: begin
        if (rise_stb && (cnt_inc == frame_len)) begin
          rx_done = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (rise_stb && (cnt_inc == 16'(GAP_CYCLES))) begin
          gap_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt      <= '0;
      sd_clk       <= 1'b0;
      sd_cmd_out   <= 1'b1;
      sd_cmd_oe    <= 1'b0;
      cnt          <= '0;
      type_q       <= RESP_NONE;
      resp_valid   <= 1'b0;
      resp_index   <= '0;
      resp_data    <= '0;
      resp_crc_err <= 1'b0;
      resp_timeout <= 1'b0;
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        sd_clk  <= ~sd_clk;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      resp_valid <= gap_done;

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            type_q       <= resp_type;
            cnt          <= '0;
            resp_index   <= '0;
            resp_data    <= '0;
            resp_crc_err <= 1'b0;
            resp_timeout <= 1'b0;
          end
        end
        ST_SEND: begin
          if (fall_stb) begin
            if (send_done) begin
              sd_cmd_oe  <= 1'b0;
              sd_cmd_out <= 1'b1;
              cnt        <= '0;
            end else begin
              sd_cmd_oe  <= 1'b1;
              sd_cmd_out <= tx_bit;
              cnt        <= cnt_inc;
            end
          end
        end
        ST_WAIT: begin
          if (rise_stb) begin
            if (rx_start) begin
              cnt <= 16'd1;
            end else if (tmo_hit) begin
              cnt          <= '0;
              resp_timeout <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_RECV: begin
          if (rise_stb) begin
            cnt <= rx_done ? '0 : cnt_inc;
            if (rx_done) begin
              if (type_q == RESP_LONG) begin
                resp_data    <= rx_next;
                resp_crc_err <= ~rx_next[0];
              end else begin
                resp_index   <= rx_next[45:40];
                resp_data    <= {96'd0, rx_next[39:8]};
                resp_crc_err <= (type_q == RESP_SHORT) & short_crc_bad;
              end
            end
          end
        end
        ST_GAP: begin
          if (rise_stb) begin
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame shift registers carry no reset; their contents only matter once a command is latched.
  always_ff @(posedge clk) begin
    if (accept) begin
      tx_sr <= {2'b01, cmd_index, cmd_arg};
    end else if (tx_crc_en) begin
      tx_sr <= {tx_sr[38:0], 1'b0};
    end
    if (rx_start) begin
      rx_sr <= '0;
    end else if ((state == ST_RECV) && rise_stb) begin
      rx_sr <= rx_next[126:0];
    end
  end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Table-driven bench for sd_cmd_engine with a behavioural SD card on the CMD line.
module tb_sd_cmd_engine;
  import sd_pkg::*;

  localparam int CLK_DIV      = 2;
  localparam int RESP_TIMEOUT = 64;
  localparam int GAP_CYCLES   = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         resp_valid;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;
  logic         resp_crc_err;
  logic         resp_timeout;
  logic         sd_clk;
  logic         sd_cmd_out;
  logic         sd_cmd_oe;
  logic         sd_cmd_in;

  always #5 clk = ~clk;

  sd_cmd_engine #(
    .CLK_DIV      (CLK_DIV),
    .RESP_TIMEOUT (RESP_TIMEOUT),
    .GAP_CYCLES   (GAP_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .resp_type    (resp_type),
    .resp_valid   (resp_valid),
    .resp_index   (resp_index),
    .resp_data    (resp_data),
    .resp_crc_err (resp_crc_err),
    .resp_timeout (resp_timeout),
    .sd_clk       (sd_clk),
    .sd_cmd_out   (sd_cmd_out),
    .sd_cmd_oe    (sd_cmd_oe),
    .sd_cmd_in    (sd_cmd_in)
  );

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    logic [47:0]  frame;
    int           rlen;
    int           rdelay;
    logic [135:0] rbits;
    logic [5:0]   e_idx;
    logic [127:0] e_data;
    logic         e_crc;
    logic         e_tmo;
    int           e_rises;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string what, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", what, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_f(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc7_f(body), 1'b1};
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    logic [47:0] fr;
    int          nb, guard, rises;
    logic        prev, got;
    @(negedge clk);
    chk($sformatf("v%0d ready_idle", id), cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_index = v.idx;
    cmd_arg   = v.arg;
    resp_type = v.rtype;
    @(negedge clk);
    chk($sformatf("v%0d ready_busy", id), cmd_ready, 1'b0);
    chk($sformatf("v%0d data_cleared", id), resp_data, 128'd0);
    chk($sformatf("v%0d flags_cleared", id), {resp_index, resp_crc_err, resp_timeout}, 8'd0);
    // A request while busy must be ignored.
    cmd_index = ~v.idx;
    cmd_arg   = ~v.arg;
    resp_type = ~v.rtype;
    @(negedge clk);
    cmd_valid = 1'b0;

    fr = '0;
    nb = 0;
    guard = 0;
    while (guard < 400) begin
      @(posedge sd_clk);
      #1;
      guard++;
      if (sd_cmd_oe) begin
        fr = {fr[46:0], sd_cmd_out};
        nb++;
      end else if (nb > 0) begin
        break;
      end
    end
    chk($sformatf("v%0d tx_frame", id), fr, v.frame);
    chk($sformatf("v%0d oe_periods", id), nb, 48);

    if (v.rlen > 0) begin
      repeat (v.rdelay) @(negedge sd_clk);
      for (int i = v.rlen - 1; i >= 0; i--) begin
        @(negedge sd_clk);
        #1;
        sd_cmd_in = v.rbits[i];
      end
      @(negedge sd_clk);
      #1;
      sd_cmd_in = 1'b1;
    end

    rises = 1;
    prev  = sd_clk;
    got   = 1'b0;
    guard = 0;
    while (guard < 3000 && !got) begin
      @(negedge clk);
      guard++;
      if (sd_clk && !prev) rises++;
      prev = sd_clk;
      if (resp_valid) got = 1'b1;
    end
    chk($sformatf("v%0d resp_valid_seen", id), got, 1'b1);
    if (v.e_rises >= 0) chk($sformatf("v%0d rise_count", id), rises, v.e_rises);
    chk($sformatf("v%0d resp_index", id), resp_index, v.e_idx);
    chk($sformatf("v%0d resp_data", id), resp_data, v.e_data);
    chk($sformatf("v%0d crc_err", id), resp_crc_err, v.e_crc);
    chk($sformatf("v%0d timeout", id), resp_timeout, v.e_tmo);
    @(negedge clk);
    chk($sformatf("v%0d valid_pulse_width", id), resp_valid, 1'b0);
    chk($sformatf("v%0d data_held", id), resp_data, v.e_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   rises, nb, guard;
    logic prev, seen;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    resp_type = '0;
    sd_cmd_in = 1'b1;

    vecs[0] = '{6'd0, 32'h0, 2'd0, 48'h40_0000_0000_95, 0, 0, 136'h0,
                6'd0, 128'h0, 1'b0, 1'b0, 8};
    vecs[1] = '{6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, 48, 2, 136'h08_0000_01AA_13,
                6'd8, 128'h1AA, 1'b0, 1'b0, -1};
    vecs[2] = '{6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, 48, 2, 136'h08_0000_01AA_11,
                6'd8, 128'h1AA, 1'b1, 1'b0, -1};
    vecs[3] = '{6'd55, 32'h0, 2'd1, mk_frame(6'd55, 32'h0), 0, 0, 136'h0,
                6'd0, 128'h0, 1'b0, 1'b1, 72};
    vecs[4] = '{6'd2, 32'h0, 2'd2, mk_frame(6'd2, 32'h0), 136, 3, {8'h3F, {16{8'hA5}}},
                6'd0, {16{8'hA5}}, 1'b0, 1'b0, -1};
    vecs[5] = '{6'd41, 32'h40FF_8000, 2'd3, mk_frame(6'd41, 32'h40FF_8000), 48, 1,
                136'h3F_80FF_8000_FF, 6'h3F, 128'h80FF_8000, 1'b0, 1'b0, -1};
    vecs[6] = '{6'd9, 32'h1234_0000, 2'd2, mk_frame(6'd9, 32'h1234_0000), 136, 2,
                {8'h3F, {15{8'hA5}}, 8'hA4}, 6'd0, {{15{8'hA5}}, 8'hA4}, 1'b1, 1'b0, -1};
    vecs[7] = '{6'd8, 32'h1AA, 2'd1, 48'h48_0000_01AA_87, 48, 4, 136'h08_0000_01AA_12,
                6'd8, 128'h1AA, 1'b1, 1'b0, -1};

    #1;
    chk("reset sd_clk", sd_clk, 1'b0);
    chk("reset cmd_out", sd_cmd_out, 1'b1);
    chk("reset cmd_oe", sd_cmd_oe, 1'b0);
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset resp_valid", resp_valid, 1'b0);
    chk("reset crc_err", resp_crc_err, 1'b0);
    chk("reset timeout", resp_timeout, 1'b0);
    chk("reset resp_index", resp_index, 6'd0);
    chk("reset resp_data", resp_data, 128'd0);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    rises = 0;
    prev  = sd_clk;
    repeat (40) begin
      @(negedge clk);
      if (sd_clk && !prev) rises++;
      prev = sd_clk;
    end
    chk("idle sd_clk rises in 40 clk", rises, 10);

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a command: outputs snap back and no completion follows.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_index = 6'd0;
    cmd_arg   = 32'h0;
    resp_type = RESP_NONE;
    @(negedge clk);
    cmd_valid = 1'b0;
    nb = 0;
    guard = 0;
    while (nb < 20 && guard < 400) begin
      @(posedge sd_clk);
      #1;
      guard++;
      if (sd_cmd_oe) nb++;
    end
    chk("midrst reached bit 20", nb, 20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst cmd_oe", sd_cmd_oe, 1'b0);
    chk("midrst cmd_ready", cmd_ready, 1'b1);
    chk("midrst cmd_out", sd_cmd_out, 1'b1);
    chk("midrst sd_clk", sd_clk, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (1500) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("midrst no resp_valid", seen, 1'b0);
    run_vec(NVEC, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
